// File: rtl/lsu_queue.sv
// lsu_queue: in-order load/store request FIFO between the load/store buffer
// and the memory controller. It issues one request at a time, broadcasts load
// results on the CDB, pulses on store completion, and kills loads on rollback.
module lsu_queue #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 4
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    input  logic                       rollback_in,
    // request side (load/store buffer)
    input  logic                       req_valid_in,
    output logic                       req_ready_out,
    input  logic                       req_write_in,
    input  logic [2:0]                 req_op_in,
    input  logic [ADDR_W-1:0]          req_addr_in,
    input  logic [XLEN-1:0]            req_data_in,
    input  logic [TAG_W-1:0]           req_tag_in,
    // memory controller side
    output logic                       mem_en_out,
    output logic                       mem_write_out,
    output logic [1:0]                 mem_size_out,
    output logic [ADDR_W-1:0]          mem_addr_out,
    output logic [XLEN-1:0]            mem_data_out,
    input  logic                       mem_end_in,
    input  logic [XLEN-1:0]            mem_data_in,
    // completion side
    output logic                       cdb_valid_out,
    output logic [TAG_W-1:0]           cdb_tag_out,
    output logic [XLEN-1:0]            cdb_data_out,
    output logic                       store_done_out,
    output logic [$clog2(DEPTH):0]     count_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    // Access size from funct3; unknown codes behave as word accesses.
    function automatic logic [1:0] op_size(input logic [2:0] op);
        logic [1:0] sz;
        case (op)
            3'b000, 3'b100: sz = 2'd0;
            3'b001, 3'b101: sz = 2'd1;
            default:        sz = 2'd2;
        endcase
        return sz;
    endfunction

    // Zero the store-data bits above the access size.
    function automatic logic [XLEN-1:0] mask_data(input logic [1:0] sz,
                                                  input logic [XLEN-1:0] d);
        logic [XLEN-1:0] r;
        case (sz)
            2'd0:    r = XLEN'(d[7:0]);
            2'd1:    r = XLEN'(d[15:0]);
            default: r = d;
        endcase
        return r;
    endfunction

    // Sign/zero extension of LSB-aligned load data.
    function automatic logic [XLEN-1:0] extend_load(input logic [2:0] op,
                                                    input logic [XLEN-1:0] d);
        logic [XLEN-1:0] r;
        case (op)
            3'b000:  r = {{(XLEN-8){d[7]}}, d[7:0]};
            3'b001:  r = {{(XLEN-16){d[15]}}, d[15:0]};
            3'b100:  r = XLEN'(d[7:0]);
            3'b101:  r = XLEN'(d[15:0]);
            default: r = d;
        endcase
        return r;
    endfunction

    // FIFO storage
    logic              ent_write_q [DEPTH];
    logic [2:0]        ent_op_q    [DEPTH];
    logic [ADDR_W-1:0] ent_addr_q  [DEPTH];
    logic [XLEN-1:0]   ent_data_q  [DEPTH];
    logic [TAG_W-1:0]  ent_tag_q   [DEPTH];
    logic              ent_live_q  [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    state_t            state_q, state_d;

    // issued entry
    logic              iss_write_q, iss_write_d;
    logic [2:0]        iss_op_q, iss_op_d;
    logic [1:0]        iss_size_q, iss_size_d;
    logic [ADDR_W-1:0] iss_addr_q, iss_addr_d;
    logic [XLEN-1:0]   iss_data_q, iss_data_d;
    logic [TAG_W-1:0]  iss_tag_q, iss_tag_d;
    logic              iss_killed_q, iss_killed_d;

    // completion outputs
    logic              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [XLEN-1:0]   cdb_data_q, cdb_data_d;
    logic              store_done_q, store_done_d;

    logic              full;
    logic              do_push;
    logic              do_pop;
    logic              head_live;

    assign full          = (count_q == CNT_W'(DEPTH));
    assign req_ready_out = ~full;

    // A load offered during rollback is dropped; stores are still accepted.
    assign do_push = rdy_in & req_valid_in & ~full & ~(rollback_in & ~req_write_in);

    // A load at the head being popped on a rollback edge counts as already
    // dead, so it is discarded instead of being issued and then killed.
    assign head_live = ent_live_q[rd_ptr_q] & ~(rollback_in & ~ent_write_q[rd_ptr_q]);

    assign do_pop = rdy_in & (state_q == IDLE) & (count_q != '0);

    // FIFO entry writes and rollback kill of queued loads
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_write_q[i] <= 1'b0;
                ent_op_q[i]    <= '0;
                ent_addr_q[i]  <= '0;
                ent_data_q[i]  <= '0;
                ent_tag_q[i]   <= '0;
                ent_live_q[i]  <= 1'b0;
            end
        end else if (rdy_in) begin
            if (rollback_in) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (!ent_write_q[i]) begin
                        ent_live_q[i] <= 1'b0;
                    end
                end
            end
            if (do_push) begin
                ent_write_q[wr_ptr_q] <= req_write_in;
                ent_op_q[wr_ptr_q]    <= req_op_in;
                ent_addr_q[wr_ptr_q]  <= req_addr_in;
                ent_data_q[wr_ptr_q]  <= req_data_in;
                ent_tag_q[wr_ptr_q]   <= req_tag_in;
                ent_live_q[wr_ptr_q]  <= 1'b1;
            end
        end
    end

    // Next-state: pointers, count, issue FSM and completion pulses
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        state_d      = state_q;
        iss_write_d  = iss_write_q;
        iss_op_d     = iss_op_q;
        iss_size_d   = iss_size_q;
        iss_addr_d   = iss_addr_q;
        iss_data_d   = iss_data_q;
        iss_tag_d    = iss_tag_q;
        iss_killed_d = iss_killed_q;
        cdb_valid_d  = cdb_valid_q;
        cdb_tag_d    = cdb_tag_q;
        cdb_data_d   = cdb_data_q;
        store_done_d = store_done_q;

        if (rdy_in) begin
            cdb_valid_d  = 1'b0;
            store_done_d = 1'b0;

            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);

            case (state_q)
                IDLE: begin
                    if (do_pop && head_live) begin
                        state_d      = ISSUE;
                        iss_write_d  = ent_write_q[rd_ptr_q];
                        iss_op_d     = ent_op_q[rd_ptr_q];
                        iss_size_d   = op_size(ent_op_q[rd_ptr_q]);
                        iss_addr_d   = ent_addr_q[rd_ptr_q];
                        iss_data_d   = mask_data(op_size(ent_op_q[rd_ptr_q]),
                                                 ent_data_q[rd_ptr_q]);
                        iss_tag_d    = ent_tag_q[rd_ptr_q];
                        iss_killed_d = 1'b0;
                    end
                end
                ISSUE: begin
                    if (mem_end_in) begin
                        state_d = IDLE;
                        if (iss_write_q) begin
                            store_done_d = 1'b1;
                        end else if (!(iss_killed_q || rollback_in)) begin
                            cdb_valid_d = 1'b1;
                            cdb_tag_d   = iss_tag_q;
                            cdb_data_d  = extend_load(iss_op_q, mem_data_in);
                        end
                    end else if (rollback_in && !iss_write_q) begin
                        iss_killed_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= IDLE;
            iss_write_q  <= 1'b0;
            iss_op_q     <= '0;
            iss_size_q   <= '0;
            iss_addr_q   <= '0;
            iss_data_q   <= '0;
            iss_tag_q    <= '0;
            iss_killed_q <= 1'b0;
            cdb_valid_q  <= 1'b0;
            cdb_tag_q    <= '0;
            cdb_data_q   <= '0;
            store_done_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            iss_write_q  <= iss_write_d;
            iss_op_q     <= iss_op_d;
            iss_size_q   <= iss_size_d;
            iss_addr_q   <= iss_addr_d;
            iss_data_q   <= iss_data_d;
            iss_tag_q    <= iss_tag_d;
            iss_killed_q <= iss_killed_d;
            cdb_valid_q  <= cdb_valid_d;
            cdb_tag_q    <= cdb_tag_d;
            cdb_data_q   <= cdb_data_d;
            store_done_q <= store_done_d;
        end
    end

    assign mem_en_out     = (state_q == ISSUE);
    assign mem_write_out  = iss_write_q;
    assign mem_size_out   = iss_size_q;
    assign mem_addr_out   = iss_addr_q;
    assign mem_data_out   = iss_data_q;
    assign cdb_valid_out  = cdb_valid_q;
    assign cdb_tag_out    = cdb_tag_q;
    assign cdb_data_out   = cdb_data_q;
    assign store_done_out = store_done_q;
    assign count_out      = count_q;

endmodule
